// File: rtl/bram_seq_pkg.sv
// Shared types and constants for the BRAM read sequencer.
// Latency: not applicable (types only).
// Backpressure: not applicable (types only).
package bram_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam logic MODE_ONCE = 1'b0;
    localparam logic MODE_LOOP = 1'b1;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line carrying the read-issue strobe and its last-mark alongside the BRAM pipeline.
// Latency: exactly RD_LAT cycles from en/mark to valid/last.
// Backpressure: none; every stage shifts each cycle.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mark,
    output logic valid,
    output logic last
);

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;

    // Shift issue strobe and last-mark; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= en;
            last_sr[0] <= en & mark;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign valid = vld_sr[RD_LAT-1];
    assign last  = last_sr[RD_LAT-1];

endmodule

// File: rtl/bram_read_sequencer.sv
// Walks BRAM addresses base..base+len-1 (once or looping) and forwards read data with last-of-pass marks.
// Latency: pl_en decoded in the RUN cycle itself; rd_valid/rd_last trail pl_en by RD_LAT; done RD_LAT+1 after final issue.
// Backpressure: pause stalls issue with address held; read data has no ready and must be consumed on rd_valid.
module bram_read_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1    // BRAM read latency, legal range 1..4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              cfg_mode,
    output logic [ADDR_W-1:0] pl_addr,
    output logic              pl_en,
    output logic              pl_wr_en,
    input  logic [DATA_W-1:0] pl_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);
    import bram_seq_pkg::*;

    // Offset is one bit wider than the address so a full 2^ADDR_W pass fits
    localparam int         OFF_W      = ADDR_W + 1;
    localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  len_m1_q;
    logic              mode_q;
    logic [OFF_W-1:0]  offset_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [2:0]        drain_cnt_q;
    logic              done_q;

    logic              issue;
    logic              at_end;
    logic [ADDR_W-1:0] cur_addr;
    logic [OFF_W-1:0]  cfg_len_m1;
    logic              pipe_valid;
    logic              pipe_last;

    // Issue decode: pause and abort both suppress the read in the same cycle
    always_comb begin
        cur_addr   = base_q + offset_q[ADDR_W-1:0];
        issue      = (state == RUN) && !pause && !abort;
        at_end     = (offset_q == len_m1_q);
        // cfg_len of zero extends to 2^ADDR_W through the extra top bit
        cfg_len_m1 = {(cfg_len == '0), cfg_len} - OFF_W'(1);
    end

    // Sequencer FSM: latch config on start, step the offset, count out the drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            len_m1_q    <= '0;
            mode_q      <= MODE_ONCE;
            offset_q    <= '0;
            last_addr_q <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= cfg_base;
                        len_m1_q <= cfg_len_m1;
                        mode_q   <= cfg_mode;
                        offset_q <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state       <= DRAIN;
                        drain_cnt_q <= DRAIN_INIT;
                    end else if (!pause) begin
                        last_addr_q <= cur_addr;
                        if (at_end) begin
                            if (mode_q == MODE_LOOP) begin
                                offset_q <= '0;
                            end else begin
                                state       <= DRAIN;
                                drain_cnt_q <= DRAIN_INIT;
                            end
                        end else begin
                            offset_q <= offset_q + OFF_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 3'd0) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue),
        .mark  (at_end),
        .valid (pipe_valid),
        .last  (pipe_last)
    );

    // Address holds the last issued value whenever no read goes out
    assign pl_en    = issue;
    assign pl_addr  = issue ? cur_addr : last_addr_q;
    assign pl_wr_en = 1'b0;
    assign rd_data  = pl_dout;
    assign rd_valid = pipe_valid;
    assign rd_last  = pipe_last;
    assign busy     = (state != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_bram_read_sequencer.sv
module tb_bram_read_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: ADDR_W=16, RD_LAT=1
    logic        a_rst_n, a_start, a_abort, a_pause, a_mode;
    logic [15:0] a_base, a_len, a_addr;
    logic        a_en, a_wr_en, a_rvalid, a_rlast, a_busy, a_done;
    logic [31:0] a_dout, a_rdata;

    // DUT B: ADDR_W=4, RD_LAT=3
    logic        b_rst_n, b_start, b_abort, b_pause, b_mode;
    logic [3:0]  b_base, b_len, b_addr;
    logic        b_en, b_wr_en, b_rvalid, b_rlast, b_busy, b_done;
    logic [31:0] b_d1, b_d2, b_dout, b_rdata;

    logic [15:0] a_addr_q[$];
    rd_exp_t     a_rd_q[$];
    logic [3:0]  b_addr_q[$];
    rd_exp_t     b_rd_q[$];

    logic [15:0] a_exp_addr;
    rd_exp_t     a_exp_rd;
    logic [3:0]  b_exp_addr;
    rd_exp_t     b_exp_rd;

    bram_read_sequencer #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort), .pause(a_pause),
        .cfg_base(a_base), .cfg_len(a_len), .cfg_mode(a_mode),
        .pl_addr(a_addr), .pl_en(a_en), .pl_wr_en(a_wr_en), .pl_dout(a_dout),
        .rd_data(a_rdata), .rd_valid(a_rvalid), .rd_last(a_rlast),
        .busy(a_busy), .done(a_done)
    );

    bram_read_sequencer #(.ADDR_W(4), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort), .pause(b_pause),
        .cfg_base(b_base), .cfg_len(b_len), .cfg_mode(b_mode),
        .pl_addr(b_addr), .pl_en(b_en), .pl_wr_en(b_wr_en), .pl_dout(b_dout),
        .rd_data(b_rdata), .rd_valid(b_rvalid), .rd_last(b_rlast),
        .busy(b_busy), .done(b_done)
    );

    function automatic logic [31:0] word_of(input logic [15:0] addr);
        return {addr ^ 16'hC3A5, addr};
    endfunction

    // BRAM models with 1- and 3-cycle read latency
    always @(posedge clk) begin
        a_dout <= word_of(a_addr);
        b_d1   <= word_of({12'h000, b_addr});
        b_d2   <= b_d1;
        b_dout <= b_d2;
    end

    // Scoreboard for DUT A
    always @(negedge clk) begin
        if (a_en) begin
            checks++;
            if (a_addr_q.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_read addr=%h required no read", a_addr);
            end else begin
                a_exp_addr = a_addr_q.pop_front();
                if (a_addr !== a_exp_addr || a_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL a_read_addr got addr=%h wr_en=%b need addr=%h wr_en=0", a_addr, a_wr_en, a_exp_addr);
                end
            end
        end
        if (a_rvalid) begin
            checks++;
            if (a_rd_q.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_valid data=%h required no valid", a_rdata);
            end else begin
                a_exp_rd = a_rd_q.pop_front();
                if (a_rdata !== a_exp_rd.data || a_rlast !== a_exp_rd.last) begin
                    errors++;
                    $display("FAIL a_rd_word got data=%h last=%b need data=%h last=%b", a_rdata, a_rlast, a_exp_rd.data, a_exp_rd.last);
                end
            end
        end
    end

    // Scoreboard for DUT B
    always @(negedge clk) begin
        if (b_en) begin
            checks++;
            if (b_addr_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_read addr=%h required no read", b_addr);
            end else begin
                b_exp_addr = b_addr_q.pop_front();
                if (b_addr !== b_exp_addr || b_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL b_read_addr got addr=%h wr_en=%b need addr=%h wr_en=0", b_addr, b_wr_en, b_exp_addr);
                end
            end
        end
        if (b_rvalid) begin
            checks++;
            if (b_rd_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_valid data=%h required no valid", b_rdata);
            end else begin
                b_exp_rd = b_rd_q.pop_front();
                if (b_rdata !== b_exp_rd.data || b_rlast !== b_exp_rd.last) begin
                    errors++;
                    $display("FAIL b_rd_word got data=%h last=%b need data=%h last=%b", b_rdata, b_rlast, b_exp_rd.data, b_exp_rd.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [15:0] base, input int n, input int len);
        for (int i = 0; i < n; i++) begin
            logic [15:0] ad;
            rd_exp_t     e;
            ad     = base + 16'(i % len);
            e.data = word_of(ad);
            e.last = ((i % len) == len - 1);
            a_addr_q.push_back(ad);
            a_rd_q.push_back(e);
        end
    endtask

    task automatic push_b(input logic [3:0] base, input int n, input int len);
        for (int i = 0; i < n; i++) begin
            logic [3:0] ad;
            rd_exp_t    e;
            ad     = base + 4'(i % len);
            e.data = word_of({12'h000, ad});
            e.last = ((i % len) == len - 1);
            b_addr_q.push_back(ad);
            b_rd_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_addr, a_en, a_wr_en, a_rvalid, a_rlast, a_busy, a_done} !== 22'h0) begin
            errors++;
            $display("FAIL reset_a got addr=%h en=%b wr=%b vld=%b last=%b busy=%b done=%b need all 0",
                     a_addr, a_en, a_wr_en, a_rvalid, a_rlast, a_busy, a_done);
        end
        checks++;
        if ({b_addr, b_en, b_wr_en, b_rvalid, b_rlast, b_busy, b_done} !== 10'h0) begin
            errors++;
            $display("FAIL reset_b got addr=%h en=%b wr=%b vld=%b last=%b busy=%b done=%b need all 0",
                     b_addr, b_en, b_wr_en, b_rvalid, b_rlast, b_busy, b_done);
        end
        step();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({a_busy, b_busy, a_en, b_en} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b%b en=%b%b need 0000", a_busy, b_busy, a_en, b_en);
        end
    endtask

    task automatic test_single_pass();
        int first_en = -1, last_en = -1, n_en = 0, done_cyc = -1;
        logic busy_run = 1'b0;
        push_a(16'h0010, 4, 4);
        a_base = 16'h0010; a_len = 16'd4; a_mode = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy_run = a_busy;
            if (a_en) begin
                n_en++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (a_done) done_cyc = cyc;
            step();
        end
        checks++;
        if (done_cyc < 0) begin errors++; $display("FAIL single_done_timeout got no done need done"); end
        checks++;
        if (busy_run !== 1'b1) begin errors++; $display("FAIL single_busy got %b need 1", busy_run); end
        checks++;
        if (n_en != 4 || first_en != 0 || last_en != 3) begin
            errors++;
            $display("FAIL single_issue got n=%0d first=%0d last=%0d need n=4 first=0 last=3", n_en, first_en, last_en);
        end
        checks++;
        if (done_cyc - last_en != 2) begin
            errors++;
            $display("FAIL single_done_timing got %0d need 2 cycles after final read", done_cyc - last_en);
        end
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse got done=%b busy=%b need 0 0", a_done, a_busy);
        end
        checks++;
        if (a_addr_q.size() != 0 || a_rd_q.size() != 0) begin
            errors++;
            $display("FAIL single_drained got addr_left=%0d rd_left=%0d need 0 0", a_addr_q.size(), a_rd_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        int n_en = 0, last_en = -1, done_cyc = -1;
        // abort while idle must not wake the block
        a_abort = 1'b1;
        step();
        step();
        checks++;
        if (a_busy !== 1'b0 || a_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort got busy=%b en=%b need 0 0", a_busy, a_en);
        end
        a_abort = 1'b0;
        push_a(16'hFFFE, 4, 4);
        a_base = 16'hFFFE; a_len = 16'd4; a_mode = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (a_en) begin n_en++; last_en = cyc; end
            if (a_done) done_cyc = cyc;
            step();
        end
        checks++;
        if (n_en != 4 || done_cyc - last_en != 2) begin
            errors++;
            $display("FAIL wrap_run got reads=%0d done_gap=%0d need reads=4 done_gap=2", n_en, done_cyc - last_en);
        end
        checks++;
        if (a_addr_q.size() != 0 || a_rd_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_drained got addr_left=%0d rd_left=%0d need 0 0", a_addr_q.size(), a_rd_q.size());
        end
    endtask

    task automatic test_start_ignored();
        int n_en = 0, last_en = -1, done_cyc = -1;
        push_a(16'h0100, 5, 5);
        a_base = 16'h0100; a_len = 16'd5; a_mode = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
            if (cyc == 2) begin
                a_start = 1'b1; a_base = 16'h0200; a_len = 16'd2; a_mode = 1'b1;
            end
            if (cyc == 3) a_start = 1'b0;
            @(negedge clk);
            if (a_en) begin n_en++; last_en = cyc; end
            if (a_done) done_cyc = cyc;
            step();
        end
        checks++;
        if (n_en != 5 || done_cyc - last_en != 2) begin
            errors++;
            $display("FAIL restart_ignored got reads=%0d done_gap=%0d need reads=5 done_gap=2", n_en, done_cyc - last_en);
        end
        step();
        step();
        checks++;
        if (a_busy !== 1'b0 || a_addr_q.size() != 0 || a_rd_q.size() != 0) begin
            errors++;
            $display("FAIL restart_idle got busy=%b addr_left=%0d rd_left=%0d need 0 0 0", a_busy, a_addr_q.size(), a_rd_q.size());
        end
    endtask

    task automatic test_loop_pause_abort();
        int n_en = 0, done_cyc = -1;
        logic [16:0] held = '0;
        logic        abort_en = 1'b1;
        push_a(16'h0040, 8, 3);
        a_base = 16'h0040; a_len = 16'd3; a_mode = 1'b1; a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            a_pause = (cyc == 4 || cyc == 5 || cyc == 10);
            a_abort = (cyc >= 10);
            @(negedge clk);
            if (cyc == 5) held = {a_en, a_addr};
            if (cyc == 10) abort_en = a_en;
            if (a_en) n_en++;
            if (a_done) done_cyc = cyc;
            step();
        end
        a_pause = 1'b0; a_abort = 1'b0;
        checks++;
        if (held !== {1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL pause_hold got en=%b addr=%h need en=0 addr=0040", held[16], held[15:0]);
        end
        checks++;
        if (abort_en !== 1'b0) begin errors++; $display("FAIL abort_cycle_en got %b need 0", abort_en); end
        checks++;
        if (n_en != 8 || done_cyc != 12) begin
            errors++;
            $display("FAIL loop_abort got reads=%0d done_cyc=%0d need reads=8 done_cyc=12", n_en, done_cyc);
        end
        checks++;
        if (a_addr_q.size() != 0 || a_rd_q.size() != 0) begin
            errors++;
            $display("FAIL loop_drained got addr_left=%0d rd_left=%0d need 0 0", a_addr_q.size(), a_rd_q.size());
        end
    endtask

    task automatic test_len_zero();
        int n_en = 0, last_en = -1, done_cyc = -1;
        push_b(4'h5, 16, 16);
        b_base = 4'h5; b_len = 4'h0; b_mode = 1'b0; b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (b_en) begin n_en++; last_en = cyc; end
            if (b_done) done_cyc = cyc;
            step();
        end
        checks++;
        if (n_en != 16 || last_en != 15 || done_cyc != 19) begin
            errors++;
            $display("FAIL len_zero got reads=%0d last_read=%0d done_cyc=%0d need 16 15 19", n_en, last_en, done_cyc);
        end
        checks++;
        if (b_addr_q.size() != 0 || b_rd_q.size() != 0) begin
            errors++;
            $display("FAIL len_zero_drained got addr_left=%0d rd_left=%0d need 0 0", b_addr_q.size(), b_rd_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        int   stray = 0;
        push_b(4'h2, 8, 8);
        b_base = 4'h2; b_len = 4'd8; b_mode = 1'b0; b_start = 1'b1;
        step();
        b_start = 1'b0;
        // two reads go out in cycles 0 and 1; their data is still in the pipe
        step();
        step();
        b_rst_n = 1'b0;
        b_addr_q.delete();
        b_rd_q.delete();
        #1;
        checks++;
        if ({b_addr, b_en, b_wr_en, b_rvalid, b_rlast, b_busy, b_done} !== 10'h0) begin
            errors++;
            $display("FAIL reset_inflight got addr=%h en=%b wr=%b vld=%b last=%b busy=%b done=%b need all 0",
                     b_addr, b_en, b_wr_en, b_rvalid, b_rlast, b_busy, b_done);
        end
        step();
        step();
        b_rst_n = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (b_rvalid || b_en || b_busy || b_done) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_discard got %0d active cycles need 0", stray);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_pause = 1'b0; a_mode = 1'b0;
        a_base = '0; a_len = '0;
        b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_pause = 1'b0; b_mode = 1'b0;
        b_base = '0; b_len = '0;
        test_reset();
        test_single_pass();
        test_addr_wrap();
        test_start_ignored();
        test_loop_pause_abort();
        test_len_zero();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
